// File: rtl/pulse_event_capture_if.sv
// Bundle between the edge-event capture stage and its polling controller.
// pending/ack handshake: pending rises on an event and stays high until the controller
// samples ack=1 on a clock edge with no coincident event; an event on that edge wins.
interface pulse_event_capture_if #(
  parameter int CNT_W = 8
);
  logic             sig_in;
  logic             cnt_clr;
  logic             ack;
  logic             evt_pulse;
  logic             stretch_out;
  logic [CNT_W-1:0] evt_cnt;
  logic             pending;
  logic             overflow;
  logic             fsm_active;

  modport master (
    output sig_in, cnt_clr, ack,
    input  evt_pulse, stretch_out, evt_cnt, pending, overflow, fsm_active
  );

  modport slave (
    input  sig_in, cnt_clr, ack,
    output evt_pulse, stretch_out, evt_cnt, pending, overflow, fsm_active
  );
endinterface

// File: rtl/pulse_event_capture.sv
// Fast-domain edge-event capture: one-cycle pulse, retriggerable stretch, saturating count,
// sticky pending. Define PULSE_EVT_BOTH_EDGE_EN to treat both edges of sig_in as events.
module pulse_event_capture #(
  parameter int CNT_W   = 8,
  parameter int STRETCH = 4
) (
  input logic                  clk,
  input logic                  rst,
  pulse_event_capture_if.slave bus
);
  localparam int REM_W = (STRETCH < 1) ? 1 : $clog2(STRETCH + 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(STRETCH - 1);

  if (STRETCH < 1) begin : g_bad_stretch
    $error("pulse_event_capture: STRETCH must be >= 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("pulse_event_capture: CNT_W must be >= 2");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               sig_q, sig_d;
  logic               evt_q, evt_d;
  logic               stretch_q, stretch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;
  logic               evt;

`ifdef PULSE_EVT_BOTH_EDGE_EN
  assign evt = bus.sig_in ^ sig_q;
`else
  assign evt = bus.sig_in & ~sig_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      sig_q     <= 1'b0;
      evt_q     <= 1'b0;
      stretch_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      sig_q     <= sig_d;
      evt_q     <= evt_d;
      stretch_q <= stretch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
    end
  end

  // Event datapath: pulse, counter with clear priority, sticky pending.
  always_comb begin
    sig_d  = bus.sig_in;
    evt_d  = evt;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    pend_d = evt | (pend_q & ~bus.ack);
    if (bus.cnt_clr) begin
      cnt_d = evt ? CNT_W'(1) : '0;
      ovf_d = 1'b0;
    end else if (evt) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (evt) state_d = ACTIVE;
      ACTIVE:  if (!evt && rem_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rem counts the stretch cycles still owed after the current one.
  always_comb begin
    rem_d     = rem_q;
    stretch_d = (state_d == ACTIVE);
    if (evt) begin
      rem_d = REM_LOAD;
    end else if (state_q == ACTIVE && rem_q != '0) begin
      rem_d = rem_q - REM_W'(1);
    end
  end

  assign bus.evt_pulse   = evt_q;
  assign bus.stretch_out = stretch_q;
  assign bus.evt_cnt     = cnt_q;
  assign bus.pending     = pend_q;
  assign bus.overflow    = ovf_q;
  assign bus.fsm_active  = (state_q == ACTIVE);
endmodule

// File: tb/tb_pulse_event_capture.sv
// Bench for pulse_event_capture: directed scenarios plus randomized traffic on two instances
// (CNT_W=8/STRETCH=4 and CNT_W=2/STRETCH=1) checked against an event-history reference model.
module tb_pulse_event_capture;
  localparam int CNT_W_A   = 8;
  localparam int STRETCH_A = 4;
  localparam int CNT_W_B   = 2;
  localparam int STRETCH_B = 1;
`ifdef PULSE_EVT_BOTH_EDGE_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_event_capture_if #(.CNT_W(CNT_W_A)) bus_a ();
  pulse_event_capture_if #(.CNT_W(CNT_W_B)) bus_b ();

  pulse_event_capture #(.CNT_W(CNT_W_A), .STRETCH(STRETCH_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  pulse_event_capture #(.CNT_W(CNT_W_B), .STRETCH(STRETCH_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: events from sampled level history, stretch from time since last event.
  int          cyc = 0;
  logic        m_prev = 1'b0;
  logic        m_evt = 1'b0;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;
  logic        m_ovf_a = 1'b0;
  logic        m_ovf_b = 1'b0;
  logic        m_pend = 1'b0;
  int          m_last_ev = -1000;
  logic [31:0] exp_q[$];

  // Driver: apply inputs, let one rising edge sample them, advance the model.
  task automatic drive(input logic s, input logic c, input logic a, input logic r);
    bus_a.sig_in  = s;
    bus_b.sig_in  = s;
    bus_a.cnt_clr = c;
    bus_b.cnt_clr = c;
    bus_a.ack     = a;
    bus_b.ack     = a;
    rst           = r;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_prev = 1'b0; m_evt = 1'b0; m_pend = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      m_last_ev = -1000;
      exp_q.delete();
    end else begin
      m_evt  = BOTH ? (s != m_prev) : (s && !m_prev);
      m_prev = s;
      if (c) begin
        m_cnt_a = m_evt ? 1 : 0; m_cnt_b = m_evt ? 1 : 0;
        m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      end else if (m_evt) begin
        if (m_cnt_a == (1 << CNT_W_A) - 1) m_ovf_a = 1'b1; else m_cnt_a++;
        if (m_cnt_b == (1 << CNT_W_B) - 1) m_ovf_b = 1'b1; else m_cnt_b++;
      end
      m_pend = m_evt || (m_pend && !a);
      if (m_evt) begin
        m_last_ev = cyc;
        exp_q.push_back(32'(cyc));
      end
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      checks++;
      if ({bus_a.evt_pulse, bus_a.stretch_out, bus_a.pending, bus_a.overflow, bus_a.fsm_active} !== 5'b0
          || bus_a.evt_cnt !== '0) begin
        errors++;
        $display("FAIL reset_idle_a cyc %0d: got evt=%b str=%b cnt=%0d pend=%b ovf=%b act=%b, want all 0",
                 i, bus_a.evt_pulse, bus_a.stretch_out, bus_a.evt_cnt, bus_a.pending, bus_a.overflow,
                 bus_a.fsm_active);
      end
      checks++;
      if ({bus_b.evt_pulse, bus_b.stretch_out, bus_b.pending, bus_b.overflow} !== 4'b0
          || bus_b.evt_cnt !== '0) begin
        errors++;
        $display("FAIL reset_idle_b cyc %0d: got evt=%b str=%b cnt=%0d pend=%b ovf=%b, want all 0",
                 i, bus_b.evt_pulse, bus_b.stretch_out, bus_b.evt_cnt, bus_b.pending, bus_b.overflow);
      end
    end
  endtask

  task automatic test_single_event();
    logic [7:0] pat;
    int n_evt, n_str, n_str_rise;
    logic prev_str;
    pat = 8'b0000_0011;
    n_evt = 0; n_str = 0; n_str_rise = 0; prev_str = 1'b0;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 0, 0, 0);
      if (i == 0) begin
        checks++;
        if (bus_a.evt_pulse !== 1'b1 || bus_a.evt_cnt !== 8'd1 || bus_a.pending !== 1'b1
            || bus_a.stretch_out !== 1'b1) begin
          errors++;
          $display("FAIL single_first_edge: got evt=%b cnt=%0d pend=%b str=%b, want 1 1 1 1",
                   bus_a.evt_pulse, bus_a.evt_cnt, bus_a.pending, bus_a.stretch_out);
        end
      end
      n_evt += int'(bus_a.evt_pulse);
      n_str += int'(bus_a.stretch_out);
      if (bus_a.stretch_out && !prev_str) n_str_rise++;
      prev_str = bus_a.stretch_out;
    end
    checks++;
    if (n_evt != (BOTH ? 2 : 1)) begin
      errors++; $display("FAIL single_evt_count: got %0d want %0d", n_evt, BOTH ? 2 : 1);
    end
    checks++;
    if (n_str != (BOTH ? 6 : 4) || n_str_rise != 1) begin
      errors++;
      $display("FAIL single_stretch: got %0d cycles in %0d runs, want %0d in 1", n_str, n_str_rise,
               BOTH ? 6 : 4);
    end
    checks++;
    if (bus_a.evt_cnt !== (BOTH ? 8'd2 : 8'd1) || bus_a.pending !== 1'b1) begin
      errors++;
      $display("FAIL single_cnt_pend: got cnt=%0d pend=%b want cnt=%0d pend=1", bus_a.evt_cnt,
               bus_a.pending, BOTH ? 2 : 1);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (bus_a.pending !== 1'b0) begin
      errors++; $display("FAIL single_ack: got pending=%b want 0", bus_a.pending);
    end
  endtask

  task automatic test_retrigger();
    logic [9:0] pat;
    int n_str, n_str_rise;
    logic prev_str;
    pat = 10'b00_0000_1001;
    n_str = 0; n_str_rise = 0; prev_str = 1'b0;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(pat[i], 0, 0, 0);
      n_str += int'(bus_a.stretch_out);
      if (bus_a.stretch_out && !prev_str) n_str_rise++;
      prev_str = bus_a.stretch_out;
    end
    checks++;
    if (n_str != (BOTH ? 8 : 7) || n_str_rise != 1) begin
      errors++;
      $display("FAIL retrigger_stretch: got %0d cycles in %0d runs, want %0d in 1", n_str,
               n_str_rise, BOTH ? 8 : 7);
    end
    checks++;
    if (bus_a.evt_cnt !== (BOTH ? 8'd4 : 8'd2)) begin
      errors++; $display("FAIL retrigger_cnt: got %0d want %0d", bus_a.evt_cnt, BOTH ? 4 : 2);
    end
  endtask

  task automatic test_saturation();
    int exp_seq[5];
    logic lvl;
    exp_seq = '{1, 2, 3, 3, 3};
    lvl = 1'b0;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      lvl = BOTH ? ~lvl : 1'b1;
      drive(lvl, 0, 0, 0);
      checks++;
      if (int'(bus_b.evt_cnt) != exp_seq[i] || bus_b.overflow !== (i >= 3)) begin
        errors++;
        $display("FAIL sat_event%0d: got cnt=%0d ovf=%b want cnt=%0d ovf=%b", i + 1, bus_b.evt_cnt,
                 bus_b.overflow, exp_seq[i], i >= 3);
      end
      drive(BOTH ? lvl : 1'b0, 0, 0, 0);
    end
    lvl = BOTH ? ~lvl : 1'b1;
    drive(lvl, 1, 0, 0);
    checks++;
    if (bus_b.evt_cnt !== 2'd1 || bus_b.overflow !== 1'b0 || bus_b.evt_pulse !== 1'b1) begin
      errors++;
      $display("FAIL sat_clr_with_rise: got cnt=%0d ovf=%b evt=%b want 1 0 1", bus_b.evt_cnt,
               bus_b.overflow, bus_b.evt_pulse);
    end
    checks++;
    if (bus_a.evt_cnt !== 8'd1 || bus_a.overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr_wide: got cnt=%0d ovf=%b want 1 0", bus_a.evt_cnt, bus_a.overflow);
    end
  endtask

  task automatic test_ack_collision();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 0, 1, 0);
    checks++;
    if (bus_a.pending !== 1'b1 || bus_a.evt_pulse !== 1'b1) begin
      errors++;
      $display("FAIL ack_vs_rise: got pend=%b evt=%b want 1 1", bus_a.pending, bus_a.evt_pulse);
    end
    drive(1, 0, 1, 0);
    checks++;
    if (bus_a.pending !== 1'b0) begin
      errors++; $display("FAIL ack_clear: got pend=%b want 0", bus_a.pending);
    end
    drive(1, 0, 1, 0);
    checks++;
    if (bus_a.pending !== 1'b0 || bus_a.evt_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: got pend=%b evt=%b want 0 0", bus_a.pending, bus_a.evt_pulse);
    end
  endtask

  task automatic test_reset_mid_stretch();
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    checks++;
    if (bus_a.stretch_out !== 1'b1 || bus_a.fsm_active !== 1'b1) begin
      errors++;
      $display("FAIL midrst_active: got str=%b act=%b want 1 1", bus_a.stretch_out, bus_a.fsm_active);
    end
    drive(1, 0, 0, 1);
    checks++;
    if (bus_a.stretch_out !== 1'b0 || bus_a.fsm_active !== 1'b0 || bus_a.evt_cnt !== '0
        || bus_a.pending !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: got str=%b act=%b cnt=%0d pend=%b want 0 0 0 0", bus_a.stretch_out,
               bus_a.fsm_active, bus_a.evt_cnt, bus_a.pending);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (bus_a.evt_pulse !== 1'b1 || bus_a.evt_cnt !== 8'd1 || bus_a.stretch_out !== 1'b1) begin
      errors++;
      $display("FAIL first_after_rst: got evt=%b cnt=%0d str=%b want 1 1 1", bus_a.evt_pulse,
               bus_a.evt_cnt, bus_a.stretch_out);
    end
  endtask

`ifdef PULSE_EVT_BOTH_EDGE_EN
  task automatic test_both_edge();
    logic [5:0] pat;
    int n_evt, first_i, last_i;
    pat = 6'b00_0111;
    n_evt = 0; first_i = -1; last_i = -1;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(pat[i], 0, 0, 0);
      if (bus_a.evt_pulse) begin
        n_evt++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    checks++;
    if (n_evt != 2 || last_i - first_i != 3 || bus_a.evt_cnt !== 8'd2) begin
      errors++;
      $display("FAIL both_edge: got %0d pulses %0d apart cnt=%0d want 2 pulses 3 apart cnt=2",
               n_evt, last_i - first_i, bus_a.evt_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic lvl, c, a, r;
    logic [31:0] exp_cyc;
    lvl = 1'b0;
    drive(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) lvl = ~lvl;
      c = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) == 0);
      drive(lvl, c, a, r);
      checks++;
      if (bus_a.evt_pulse !== m_evt || bus_a.stretch_out !== ((cyc - m_last_ev) < STRETCH_A)
          || bus_a.fsm_active !== ((cyc - m_last_ev) < STRETCH_A)) begin
        errors++;
        $display("FAIL rand_a_pulse cyc %0d: got evt=%b str=%b act=%b want evt=%b str=%b", cyc,
                 bus_a.evt_pulse, bus_a.stretch_out, bus_a.fsm_active, m_evt,
                 (cyc - m_last_ev) < STRETCH_A);
      end
      checks++;
      if (int'(bus_a.evt_cnt) != m_cnt_a || bus_a.overflow !== m_ovf_a || bus_a.pending !== m_pend) begin
        errors++;
        $display("FAIL rand_a_state cyc %0d: got cnt=%0d ovf=%b pend=%b want cnt=%0d ovf=%b pend=%b",
                 cyc, bus_a.evt_cnt, bus_a.overflow, bus_a.pending, m_cnt_a, m_ovf_a, m_pend);
      end
      checks++;
      if (int'(bus_b.evt_cnt) != m_cnt_b || bus_b.overflow !== m_ovf_b
          || bus_b.stretch_out !== ((cyc - m_last_ev) < STRETCH_B)) begin
        errors++;
        $display("FAIL rand_b cyc %0d: got cnt=%0d ovf=%b str=%b want cnt=%0d ovf=%b str=%b", cyc,
                 bus_b.evt_cnt, bus_b.overflow, bus_b.stretch_out, m_cnt_b, m_ovf_b,
                 (cyc - m_last_ev) < STRETCH_B);
      end
      if (bus_a.evt_pulse === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_sb_unexpected cyc %0d: got pulse, want none", cyc);
        end else begin
          exp_cyc = exp_q.pop_front();
          if (exp_cyc != 32'(cyc)) begin
            errors++;
            $display("FAIL rand_sb_cycle: got pulse at %0d want %0d", cyc, exp_cyc);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_sb_missing: got %0d events unobserved, want 0", exp_q.size());
    end
  endtask

  initial begin
    bus_a.sig_in = 1'b0; bus_b.sig_in = 1'b0;
    bus_a.cnt_clr = 1'b0; bus_b.cnt_clr = 1'b0;
    bus_a.ack = 1'b0; bus_b.ack = 1'b0;
    test_reset();
    test_single_event();
    test_retrigger();
    test_saturation();
    test_ack_collision();
    test_reset_mid_stretch();
`ifdef PULSE_EVT_BOTH_EDGE_EN
    test_both_edge();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_event_capture.md
Name: pulse_event_capture

Overview:
Fast-domain consumer stage placed directly after the slow-to-fast pulse synchronizer. Takes the synchronizer's already-synchronized output level and detects rising edges. For each edge it produces a clean one-cycle event pulse, a retriggerable stretched pulse, and a saturating event count. A sticky pending flag with ack handshake is provided for a polling controller.

Parameters:
CNT_W, 8, width of event counter (>=2)
STRETCH, 4, length in clk cycles of stretch_out per event (>=1; 0 is illegal, flag with a compile-time check)

Ports:
clk  input  1  single clock (fast domain); all logic is on its rising edge
rst  input  1  synchronous, active-high reset
sig_in  input  1  synchronized level from the upstream synchronizer; already in the clk domain, no further synchronization in this block
evt_pulse  output  1  one-cycle pulse per detected event
stretch_out  output  1  high for STRETCH cycles after the last event
evt_cnt  output  CNT_W  saturating event count
cnt_clr  input  1  clears evt_cnt and overflow
pending  output  1  sticky "event occurred" flag
ack  input  1  clears pending
overflow  output  1  sticky; set when an event arrives while evt_cnt is all-ones

Behaviour:
- Reset: on a clk edge with rst=1, all registers clear. sig_d, evt_pulse, stretch_out, evt_cnt, pending, overflow = 0, and the FSM enters IDLE. rst has priority over every other input.
- Edge detect: sig_d <= sig_in each cycle. rise = sig_in & ~sig_d, a combinational function of registered sig_d.
- evt_pulse <= rise, so it is high for exactly one cycle. It asserts on the first edge that samples sig_in=1 after a sampled 0. A long high on sig_in produces one event only.
- The first cycle after reset has sig_d=0. If sig_in=1 there, that counts as an event.
- Counter, updated on the same edge as evt_pulse:
  - cnt_clr & rise -> evt_cnt=1, overflow=0 (event not lost).
  - cnt_clr only -> evt_cnt=0, overflow=0.
  - rise & evt_cnt==all-ones -> evt_cnt holds, overflow=1.
  - rise otherwise -> evt_cnt+1.
- Pending handshake: set on rise, cleared on ack. If rise and ack coincide, set wins and pending stays 1. ack while pending=0 has no effect.
- Stretch FSM, states IDLE and ACTIVE, with down-counter rem of width clog2(STRETCH+1):
  - IDLE + rise -> ACTIVE, rem=STRETCH-1, stretch_out=1.
  - ACTIVE + rise -> rem reloads to STRETCH-1 (retrigger; no gap, no extra edge).
  - ACTIVE, no rise, rem==0 -> IDLE, stretch_out=0.
  - ACTIVE, no rise, rem!=0 -> rem-1.
  - stretch_out is registered and rises on the same edge as evt_pulse.
  - With STRETCH=1, stretch_out equals evt_pulse.
- Reset mid-operation: rst during ACTIVE forces IDLE, and stretch_out drops on that edge.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
PULSE_EVT_BOTH_EDGE_EN
- Defined: the event condition becomes sig_in ^ sig_d, so rising and falling edges each produce evt_pulse, count, pending and stretch.
- Undefined: rising edges only, as above.
- Port list is identical in both builds.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with sig_in=0, then 10 cycles idle -> all outputs 0 throughout.
- Single event, sig_in high for 2 cycles: evt_pulse=1 for exactly 1 cycle, evt_cnt 0->1, pending=1, and stretch_out=1 for exactly 4 cycles (STRETCH=4). Then ack for 1 cycle -> pending=0 on the next cycle.
- Retrigger: two rises 3 cycles apart (sig_in 1,0,0,1) -> stretch_out continuously high for 3+4=7 cycles, evt_cnt=2.
- Saturation, CNT_W=2: 5 separated events -> evt_cnt sequence 1,2,3,3,3, with overflow=1 from the 4th event. Then cnt_clr coincident with a 6th rise -> evt_cnt=1, overflow=0.
- Simultaneous ack and rise while pending=1 -> pending remains 1. rst asserted mid-stretch (2 cycles into ACTIVE) -> stretch_out=0 on the next edge and the FSM is in IDLE.
- With PULSE_EVT_BOTH_EDGE_EN defined: one high pulse of 3 cycles on sig_in -> 2 evt_pulses 3 cycles apart, evt_cnt=2.
